gate_mem_ctrl: RTL and testbench
================================

GATE_MEM_CTRL -- requirements
Module: gate_mem_ctrl

Interface
REQ-001 SHALL have parameter N_ENDPOINTS, default 1, range 1..16: number of endpoint entries managed.
REQ-002 SHALL have parameter DRAIN_TIMEOUT, default 4096: maximum number of drain cycles before a commit aborts.
REQ-003 SHALL have parameter CNT_BITS, default 16: width of the outstanding-request counter.
REQ-004 aclk  in  1  the single clock; all logic rising-edge.
REQ-005 areset  in  1  asynchronous, active-high reset.
REQ-006 cfg_valid/cfg_ready  in/out  1/1  endpoint staging write handshake.
REQ-007 cfg_idx  in  clog2(N_ENDPOINTS) (min 1)  shadow entry to write.
REQ-008 cfg_base, cfg_bound  in  48/48  region vaddr base and inclusive bound.
REQ-009 cfg_rights  in  2  access rights: [1]=write, [0]=read.
REQ-010 cfg_en  in  1  entry valid bit.
REQ-011 commit_valid/commit_ready  in/out  1/1  request to atomically publish the shadow table.
REQ-012 req_issue  in  1  pulse: one request accepted downstream of the gateway.
REQ-013 req_done  in  1  pulse: one request completed.
REQ-014 gate_hold  out  1  high = upstream must stop presenting new requests.
REQ-015 ep_ctrl  out  99*N_ENDPOINTS  active table; per entry [98] valid, [97:96] rights, [95:48] bound, [47:0] base.
REQ-016 busy  out  1  high whenever state is not IDLE.
REQ-017 commit_done, commit_timeout  out  1/1  single-cycle status pulses.
REQ-018 cfg_err, cnt_err  out  1/1  sticky error flags.
REQ-019 err_clr  in  1  pulse: clears both sticky error flags.

Function
REQ-020 States SHALL be IDLE, HOLD, DRAIN, SWAP, DONE.
REQ-021 cfg_ready SHALL be 1 only in IDLE; commit_ready SHALL be 1 only in IDLE with cfg_valid=0 (a staging write wins over a commit in the same cycle).
REQ-022 A cfg handshake with cfg_en=1 and cfg_base>cfg_bound SHALL write the shadow entry with valid=0 and set cfg_err; otherwise it SHALL write all fields as given.
REQ-023 A cfg_idx >= N_ENDPOINTS SHALL be accepted, SHALL leave the shadow table unchanged, and SHALL set cfg_err.
REQ-024 Transitions: IDLE->HOLD on commit handshake; HOLD->DRAIN after exactly 1 cycle; DRAIN->SWAP when the outstanding count is 0; DRAIN->IDLE on timeout; SWAP->DONE after 1 cycle; DONE->IDLE after 1 cycle.
REQ-025 gate_hold SHALL be 1 in HOLD, DRAIN and SWAP, and 0 in IDLE and DONE.
REQ-026 In SWAP, all entries of the shadow table SHALL be copied to the active table in one cycle; ep_ctrl SHALL change only on that edge.
REQ-027 commit_done SHALL pulse in DONE; with an idle datapath, minimum latency from the commit handshake to commit_done is 4 cycles.
REQ-028 The drain timer SHALL clear on entry to DRAIN; when it reaches DRAIN_TIMEOUT, the block SHALL pulse commit_timeout, return to IDLE, leave the active table unchanged, and retain the shadow table.
REQ-029 The outstanding counter SHALL increment on req_issue and decrement on req_done; both in the same cycle SHALL leave it unchanged.
REQ-030 req_done at count 0 SHALL hold the count at 0 and set cnt_err; req_issue at the maximum count SHALL saturate and set cnt_err.
REQ-031 The counter SHALL track in all states, including requests already in flight when gate_hold rises.
REQ-032 err_clr SHALL clear the sticky flags; a set event in the same cycle SHALL win over the clear.

Reset
REQ-033 While areset is high: state=IDLE; shadow and active tables all zero (every entry invalid); ep_ctrl=0; counter=0; gate_hold=0; busy=0; cfg_ready=0; commit_ready=0; all pulses and sticky flags 0.
REQ-034 On reset assertion mid-commit, the block SHALL abort immediately with no partial table swap visible on ep_ctrl.

Structure
REQ-035 The entry field widths/offsets (48/48/2/1, total 99) and the state enum SHALL live in lynxTypes, shared with the gateway.
REQ-036 The outstanding counter with its saturation and cnt_err logic SHALL be a sub-module named gate_mem_inflight.

Verification
REQ-037 Stage idx0 base=0x1000 bound=0x1FFF rights=2'b01 en=1, then commit with no traffic -> commit_done 4 cycles after the handshake; ep_ctrl[98:0] = {1,01,0x1FFF,0x1000}.
REQ-038 3 req_issue pulses, then commit, then 3 req_done pulses spaced 10 cycles apart -> gate_hold high throughout; SWAP occurs the cycle after the third done.
REQ-039 DRAIN_TIMEOUT=16, 1 outstanding request, commit -> commit_timeout pulse after 16 DRAIN cycles; ep_ctrl unchanged; gate_hold=0.
REQ-040 Staging write with base=0x2000, bound=0x1000, en=1 -> cfg_err=1 and the entry commits with valid=0; err_clr -> cfg_err=0.
REQ-041 req_done at count 0 -> cnt_err=1 and count stays 0; req_issue and req_done in the same cycle at count 5 -> count stays 5.
REQ-042 Assert areset during DRAIN -> ep_ctrl=0, state=IDLE, gate_hold=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/lynxTypes.sv
// Types shared between the memory gateway and its controller: endpoint entry layout
// and the commit state machine encoding.
package lynxTypes;

  localparam int ADDR_W   = 48;
  localparam int RIGHTS_W = 2;

  // Packed layout gives [98] valid, [97:96] rights, [95:48] bound, [47:0] base.
  typedef struct packed {
    logic                valid;
    logic [RIGHTS_W-1:0] rights;
    logic [ADDR_W-1:0]   bound;
    logic [ADDR_W-1:0]   base;
  } ep_entry_t;

  localparam int ENTRY_W = $bits(ep_entry_t);

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    DRAIN,
    SWAP,
    DONE
  } gate_state_t;

  // An enabled entry whose base lies above its bound is stored but never marked valid.
  function automatic ep_entry_t make_entry(input logic                en,
                                           input logic [RIGHTS_W-1:0] rights,
                                           input logic [ADDR_W-1:0]   bound,
                                           input logic [ADDR_W-1:0]   base);
    ep_entry_t e;
    e.valid  = en && (base <= bound);
    e.rights = rights;
    e.bound  = bound;
    e.base   = base;
    return e;
  endfunction

endpackage

// File: rtl/gate_mem_inflight.sv
// Outstanding-request counter behind the gateway, saturating at both ends with a
// sticky error flag for underflow/overflow attempts.
module gate_mem_inflight #(
  parameter int CNT_BITS = 16
) (
  input  logic aclk,
  input  logic areset,
  input  logic req_issue,
  input  logic req_done,
  input  logic err_clr,
  output logic drained,
  output logic cnt_err
);

  logic [CNT_BITS-1:0] count;
  logic [CNT_BITS-1:0] count_nxt;
  logic                err_evt;

  // Returns {error_event, next_count}; simultaneous issue and done cancel out.
  function automatic logic [CNT_BITS:0] sat_update(input logic [CNT_BITS-1:0] c,
                                                   input logic                inc,
                                                   input logic                dec);
    logic                err;
    logic [CNT_BITS-1:0] nxt;
    err = 1'b0;
    nxt = c;
    if (inc && !dec) begin
      if (&c) err = 1'b1;
      else    nxt = c + CNT_BITS'(1);
    end else if (dec && !inc) begin
      if (c == '0) err = 1'b1;
      else         nxt = c - CNT_BITS'(1);
    end
    return {err, nxt};
  endfunction

  always_comb begin
    {err_evt, count_nxt} = sat_update(count, req_issue, req_done);
  end

  // Looks at the post-update count so a drain can finish in the cycle the last done lands.
  assign drained = (count_nxt == '0);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      count   <= '0;
      cnt_err <= 1'b0;
    end else begin
      count   <= count_nxt;
      cnt_err <= err_evt | (cnt_err & ~err_clr);
    end
  end

endmodule

// File: rtl/gate_mem_ctrl.sv
// Endpoint table controller: stages entries into a shadow table and publishes it
// atomically once the gateway has been held and all outstanding requests drained.
module gate_mem_ctrl
  import lynxTypes::*;
#(
  parameter int  N_ENDPOINTS   = 1,
  parameter int  DRAIN_TIMEOUT = 4096,
  parameter int  CNT_BITS      = 16,
  localparam int IDX_W         = (N_ENDPOINTS > 1) ? $clog2(N_ENDPOINTS) : 1
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic                           cfg_valid,
  output logic                           cfg_ready,
  input  logic [IDX_W-1:0]               cfg_idx,
  input  logic [ADDR_W-1:0]              cfg_base,
  input  logic [ADDR_W-1:0]              cfg_bound,
  input  logic [RIGHTS_W-1:0]            cfg_rights,
  input  logic                           cfg_en,
  input  logic                           commit_valid,
  output logic                           commit_ready,
  input  logic                           req_issue,
  input  logic                           req_done,
  output logic                           gate_hold,
  output logic [ENTRY_W*N_ENDPOINTS-1:0] ep_ctrl,
  output logic                           busy,
  output logic                           commit_done,
  output logic                           commit_timeout,
  output logic                           cfg_err,
  output logic                           cnt_err,
  input  logic                           err_clr
);

  localparam int              TMR_W    = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DRAIN_TIMEOUT - 1);

  gate_state_t                    state, state_nxt;
  logic [TMR_W-1:0]               drain_tmr;
  logic [ENTRY_W*N_ENDPOINTS-1:0] shadow_tbl, active_tbl;
  logic                           drained, tbl_swap;
  logic                           cfg_hs, idx_bad, range_bad, cfg_err_set;
  int                             cfg_idx_int;
  ep_entry_t                      new_entry;

  gate_mem_inflight #(
    .CNT_BITS(CNT_BITS)
  ) u_inflight (
    .aclk     (aclk),
    .areset   (areset),
    .req_issue(req_issue),
    .req_done (req_done),
    .err_clr  (err_clr),
    .drained  (drained),
    .cnt_err  (cnt_err)
  );

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Ready outputs are masked by areset so nothing handshakes while reset is held.
  always_comb begin
    state_nxt      = state;
    cfg_ready      = 1'b0;
    commit_ready   = 1'b0;
    gate_hold      = 1'b0;
    commit_done    = 1'b0;
    commit_timeout = 1'b0;
    tbl_swap       = 1'b0;
    busy           = (state != IDLE);
    case (state)
      IDLE: begin
        cfg_ready    = !areset;
        commit_ready = !areset && !cfg_valid;
        if (commit_valid && !areset && !cfg_valid) state_nxt = HOLD;
      end
      HOLD: begin
        gate_hold = 1'b1;
        state_nxt = DRAIN;
      end
      DRAIN: begin
        gate_hold = 1'b1;
        if (drained) begin
          state_nxt = SWAP;
        end else if (drain_tmr == TMR_LAST) begin
          commit_timeout = 1'b1;
          state_nxt      = IDLE;
        end
      end
      SWAP: begin
        gate_hold = 1'b1;
        tbl_swap  = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        commit_done = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset)               drain_tmr <= '0;
    else if (state == HOLD)   drain_tmr <= '0;
    else if (state == DRAIN)  drain_tmr <= drain_tmr + TMR_W'(1);
  end

  assign cfg_idx_int = int'(cfg_idx);
  assign cfg_hs      = cfg_valid && cfg_ready;
  assign idx_bad     = (cfg_idx_int >= N_ENDPOINTS);
  assign range_bad   = cfg_en && (cfg_base > cfg_bound);
  assign cfg_err_set = cfg_hs && (idx_bad || range_bad);
  assign new_entry   = make_entry(cfg_en, cfg_rights, cfg_bound, cfg_base);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      shadow_tbl <= '0;
    end else if (cfg_hs && !idx_bad) begin
      for (int i = 0; i < N_ENDPOINTS; i++) begin
        if (cfg_idx_int == i) shadow_tbl[i*ENTRY_W +: ENTRY_W] <= new_entry;
      end
    end
  end

  // The active table only moves on the SWAP edge, so a timeout or reset never exposes a partial copy.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset)        active_tbl <= '0;
    else if (tbl_swap) active_tbl <= shadow_tbl;
  end

  assign ep_ctrl = active_tbl;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) cfg_err <= 1'b0;
    else        cfg_err <= cfg_err_set | (cfg_err & ~err_clr);
  end

endmodule

// File: tb/tb_gate_mem_ctrl.sv
// Bench for gate_mem_ctrl: a main instance with the default drain timeout and a second
// instance with a 16-cycle timeout, both checked against a table/counter reference model.
module tb_gate_mem_ctrl;

  localparam int N   = 3;
  localparam int CB  = 4;
  localparam int EW  = 99;
  localparam int TMO = 16;
  localparam int MAXC = (1 << CB) - 1;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          cfg_valid = 1'b0, cfg_en = 1'b0, commit_valid = 1'b0;
  logic [1:0]    cfg_idx = '0, cfg_rights = '0;
  logic [47:0]   cfg_base = '0, cfg_bound = '0;
  logic          req_issue = 1'b0, req_done = 1'b0, err_clr = 1'b0;

  logic          cfg_ready, commit_ready, gate_hold, busy, commit_done, commit_timeout, cfg_err, cnt_err;
  logic [EW*N-1:0] ep_ctrl;
  logic          t_cfg_ready, t_commit_ready, t_gate_hold, t_busy, t_commit_done, t_commit_timeout, t_cfg_err, t_cnt_err;
  logic [EW*N-1:0] t_ep_ctrl;

  gate_mem_ctrl #(.N_ENDPOINTS(N), .CNT_BITS(CB)) dut (
    .aclk(aclk), .areset(areset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_idx(cfg_idx),
    .cfg_base(cfg_base), .cfg_bound(cfg_bound), .cfg_rights(cfg_rights), .cfg_en(cfg_en),
    .commit_valid(commit_valid), .commit_ready(commit_ready), .req_issue(req_issue), .req_done(req_done),
    .gate_hold(gate_hold), .ep_ctrl(ep_ctrl), .busy(busy), .commit_done(commit_done),
    .commit_timeout(commit_timeout), .cfg_err(cfg_err), .cnt_err(cnt_err), .err_clr(err_clr));

  gate_mem_ctrl #(.N_ENDPOINTS(N), .DRAIN_TIMEOUT(TMO), .CNT_BITS(CB)) dut_t (
    .aclk(aclk), .areset(areset), .cfg_valid(cfg_valid), .cfg_ready(t_cfg_ready), .cfg_idx(cfg_idx),
    .cfg_base(cfg_base), .cfg_bound(cfg_bound), .cfg_rights(cfg_rights), .cfg_en(cfg_en),
    .commit_valid(commit_valid), .commit_ready(t_commit_ready), .req_issue(req_issue), .req_done(req_done),
    .gate_hold(t_gate_hold), .ep_ctrl(t_ep_ctrl), .busy(t_busy), .commit_done(t_commit_done),
    .commit_timeout(t_commit_timeout), .cfg_err(t_cfg_err), .cnt_err(t_cnt_err), .err_clr(err_clr));

  always #5 aclk = ~aclk;

  int total = 0;
  int bad = 0;

  // Reference model: shadow/active tables, outstanding count, sticky flags.
  logic [EW-1:0] m_shadow [N];
  logic [EW-1:0] m_active [N];
  int            m_cnt;
  logic          m_cfg_err, m_cnt_err;

  function automatic logic [EW*N-1:0] exp_ep();
    logic [EW*N-1:0] r;
    for (int i = 0; i < N; i++) r[i*EW +: EW] = m_active[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_shadow[i] = '0;
      m_active[i] = '0;
    end
    m_cnt = 0;
    m_cfg_err = 1'b0;
    m_cnt_err = 1'b0;
  endtask

  // Applies one clock edge's worth of inputs to the model (cfg only driven while idle).
  task automatic model_edge();
    bit   set_c, set_n;
    logic v;
    set_c = 0;
    set_n = 0;
    if (cfg_valid) begin
      if (int'(cfg_idx) >= N) begin
        set_c = 1;
      end else begin
        v = cfg_en;
        if (cfg_en && cfg_base > cfg_bound) begin
          v = 1'b0;
          set_c = 1;
        end
        m_shadow[int'(cfg_idx)] = {v, cfg_rights, cfg_bound, cfg_base};
      end
    end
    m_cfg_err = set_c | (m_cfg_err & !err_clr);
    if (req_issue && !req_done) begin
      if (m_cnt == MAXC) set_n = 1; else m_cnt = m_cnt + 1;
    end else if (req_done && !req_issue) begin
      if (m_cnt == 0) set_n = 1; else m_cnt = m_cnt - 1;
    end
    m_cnt_err = set_n | (m_cnt_err & !err_clr);
  endtask

  task automatic step();
    @(posedge aclk);
    model_edge();
    #1;
  endtask

  task automatic stage(input logic [1:0] idx, input logic [47:0] b, input logic [47:0] bd,
                       input logic [1:0] rt, input logic en);
    cfg_valid = 1'b1; cfg_idx = idx; cfg_base = b; cfg_bound = bd; cfg_rights = rt; cfg_en = en;
    step();
    cfg_valid = 1'b0;
  endtask

  // Steps from the cycle after a commit handshake until done/timeout; lat counts cycles since the handshake.
  task automatic wait_end(input int budget, output int lat, output bit d, output bit t,
                          output int hold_bad, output int ep_early);
    logic [EW*N-1:0] ep0;
    ep0 = ep_ctrl; lat = 1; d = 0; t = 0; hold_bad = 0; ep_early = 0;
    while (lat <= budget) begin
      if (commit_done === 1'b1) begin d = 1; break; end
      if (commit_timeout === 1'b1) begin t = 1; break; end
      if (gate_hold !== 1'b1) hold_bad++;
      if (ep_ctrl !== ep0) ep_early++;
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge aclk);
    #1;
    model_reset();
    total++; if (ep_ctrl !== '0) begin bad++; $display("FAIL rst_ep got=%0h want=0", ep_ctrl); end
    total++; if (gate_hold !== 1'b0) begin bad++; $display("FAIL rst_hold got=%0b want=0", gate_hold); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b want=0", busy); end
    total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL rst_cfg_ready got=%0b want=0", cfg_ready); end
    total++; if (commit_ready !== 1'b0) begin bad++; $display("FAIL rst_commit_ready got=%0b want=0", commit_ready); end
    total++; if ({commit_done, commit_timeout, cfg_err, cnt_err} !== 4'b0) begin bad++; $display("FAIL rst_flags got=%0b want=0", {commit_done, commit_timeout, cfg_err, cnt_err}); end
    areset = 1'b0;
    step();
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL idle_cfg_ready got=%0b want=1", cfg_ready); end
    total++; if (commit_ready !== 1'b1) begin bad++; $display("FAIL idle_commit_ready got=%0b want=1", commit_ready); end
    cfg_valid = 1'b1;
    #1;
    total++; if (commit_ready !== 1'b0) begin bad++; $display("FAIL cfg_beats_commit got=%0b want=0", commit_ready); end
    cfg_valid = 1'b0;
  endtask

  task automatic test_basic_commit();
    int lat, hb, ee; bit d, t;
    logic [EW-1:0] want0;
    want0 = {1'b1, 2'b01, 48'h1FFF, 48'h1000};
    stage(2'd0, 48'h1000, 48'h1FFF, 2'b01, 1'b1);
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL basic_cfg_err got=%0b want=0", cfg_err); end
    commit_valid = 1'b1;
    step();
    commit_valid = 1'b0;
    wait_end(20, lat, d, t, hb, ee);
    if (d) for (int i = 0; i < N; i++) m_active[i] = m_shadow[i];
    total++; if (!d || lat != 4) begin bad++; $display("FAIL basic_latency got=%0d done=%0b want=4", lat, d); end
    total++; if (hb != 0 || ee != 0) begin bad++; $display("FAIL basic_hold got=%0d/%0d want=0/0", hb, ee); end
    total++; if (ep_ctrl[EW-1:0] !== want0) begin bad++; $display("FAIL basic_entry0 got=%0h want=%0h", ep_ctrl[EW-1:0], want0); end
    total++; if (gate_hold !== 1'b0) begin bad++; $display("FAIL basic_done_hold got=%0b want=0", gate_hold); end
    step();
    total++; if (busy !== 1'b0 || commit_done !== 1'b0) begin bad++; $display("FAIL basic_back_idle got=%0b%0b want=00", busy, commit_done); end
  endtask

  task automatic test_back_to_back();
    int hb;
    logic [47:0] b;
    logic [EW*N-1:0] old_ep;
    b = {16'h0, 32'($urandom)};
    stage(2'd1, b, b + 48'($urandom_range(0, 4095)), 2'($urandom), 1'b1);
    req_issue = 1'b1;
    repeat (3) step();
    req_issue = 1'b0;
    total++; if (dut.u_inflight.count !== 4'(m_cnt) || m_cnt != 3) begin bad++; $display("FAIL b2b_count got=%0d want=3", dut.u_inflight.count); end
    old_ep = exp_ep();
    commit_valid = 1'b1;
    step();
    commit_valid = 1'b0;
    hb = 0;
    for (int k = 0; k < 3; k++) begin
      repeat (9) begin
        if (gate_hold !== 1'b1) hb++;
        step();
      end
      if (gate_hold !== 1'b1) hb++;
      req_done = 1'b1;
      step();
      req_done = 1'b0;
    end
    total++; if (hb != 0) begin bad++; $display("FAIL b2b_hold_drop got=%0d want=0", hb); end
    total++; if (gate_hold !== 1'b1 || commit_done !== 1'b0) begin bad++; $display("FAIL b2b_swap_cycle got=%0b%0b want=10", gate_hold, commit_done); end
    total++; if (ep_ctrl !== old_ep) begin bad++; $display("FAIL b2b_ep_early got=%0h want=%0h", ep_ctrl, old_ep); end
    step();
    for (int i = 0; i < N; i++) m_active[i] = m_shadow[i];
    total++; if (commit_done !== 1'b1) begin bad++; $display("FAIL b2b_done got=%0b want=1", commit_done); end
    total++; if (ep_ctrl !== exp_ep()) begin bad++; $display("FAIL b2b_ep got=%0h want=%0h", ep_ctrl, exp_ep()); end
    step();
  endtask

  task automatic test_cfg_err();
    int lat, hb, ee; bit d, t;
    stage(2'd2, 48'h2000, 48'h1000, 2'b11, 1'b1);
    total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL range_err got=%0b want=1", cfg_err); end
    err_clr = 1'b1; step(); err_clr = 1'b0;
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL range_clr got=%0b want=0", cfg_err); end
    stage(2'd3, 48'h0, 48'hFFFF, 2'b10, 1'b1);
    total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL idx_err got=%0b want=1", cfg_err); end
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL idx_ready got=%0b want=1", cfg_ready); end
    err_clr = 1'b1;
    stage(2'd1, 48'h10, 48'h5, 2'b01, 1'b1);
    err_clr = 1'b0;
    total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL set_beats_clr got=%0b want=1", cfg_err); end
    err_clr = 1'b1; step(); err_clr = 1'b0;
    commit_valid = 1'b1; step(); commit_valid = 1'b0;
    wait_end(20, lat, d, t, hb, ee);
    if (d) for (int i = 0; i < N; i++) m_active[i] = m_shadow[i];
    total++; if (!d || lat != 4) begin bad++; $display("FAIL err_commit_lat got=%0d want=4", lat); end
    total++; if (ep_ctrl !== exp_ep()) begin bad++; $display("FAIL err_commit_ep got=%0h want=%0h", ep_ctrl, exp_ep()); end
    total++; if (ep_ctrl[2*EW +: EW] !== {1'b0, 2'b11, 48'h1000, 48'h2000}) begin bad++; $display("FAIL entry2_invalid got=%0h want=%0h", ep_ctrl[2*EW +: EW], {1'b0, 2'b11, 48'h1000, 48'h2000}); end
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL err_after_clr got=%0b want=0", cfg_err); end
    step();
  endtask

  task automatic test_counter();
    while (m_cnt > 0) begin req_done = 1'b1; step(); end
    req_done = 1'b0;
    err_clr = 1'b1; step(); err_clr = 1'b0;
    req_done = 1'b1; step(); req_done = 1'b0;
    total++; if (cnt_err !== 1'b1 || dut.u_inflight.count !== 4'd0) begin bad++; $display("FAIL underflow got=%0b/%0d want=1/0", cnt_err, dut.u_inflight.count); end
    err_clr = 1'b1; step(); err_clr = 1'b0;
    req_issue = 1'b1; repeat (5) step();
    req_done = 1'b1; step();
    req_issue = 1'b0; req_done = 1'b0;
    total++; if (dut.u_inflight.count !== 4'd5 || cnt_err !== 1'b0) begin bad++; $display("FAIL both_pulses got=%0d/%0b want=5/0", dut.u_inflight.count, cnt_err); end
    req_issue = 1'b1; repeat (10) step();
    total++; if (dut.u_inflight.count !== 4'(MAXC) || cnt_err !== 1'b0) begin bad++; $display("FAIL at_max got=%0d/%0b want=%0d/0", dut.u_inflight.count, cnt_err, MAXC); end
    step();
    total++; if (dut.u_inflight.count !== 4'(MAXC) || cnt_err !== 1'b1) begin bad++; $display("FAIL overflow got=%0d/%0b want=%0d/1", dut.u_inflight.count, cnt_err, MAXC); end
    err_clr = 1'b1; step();
    req_issue = 1'b0;
    total++; if (cnt_err !== 1'b1) begin bad++; $display("FAIL cnt_set_beats_clr got=%0b want=1", cnt_err); end
    step(); err_clr = 1'b0;
    total++; if (cnt_err !== 1'b0) begin bad++; $display("FAIL cnt_clr got=%0b want=0", cnt_err); end
    req_done = 1'b1; repeat (MAXC) step(); req_done = 1'b0;
    total++; if (dut.u_inflight.count !== 4'(m_cnt) || m_cnt != 0) begin bad++; $display("FAIL cnt_drain got=%0d want=0", dut.u_inflight.count); end
  endtask

  task automatic test_random();
    int lat, hb, ee; bit d, t;
    logic [47:0] b, bd;
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 4; k++) begin
        b  = {16'($urandom), 32'($urandom)};
        bd = ($urandom_range(0, 1) == 1) ? b + 48'($urandom_range(0, 65535)) : {16'($urandom), 32'($urandom)};
        err_clr = ($urandom_range(0, 7) == 0);
        stage(2'($urandom_range(0, 3)), b, bd, 2'($urandom), 1'($urandom));
        err_clr = 1'b0;
      end
      total++; if (cfg_err !== m_cfg_err) begin bad++; $display("FAIL rnd_cfg_err r=%0d got=%0b want=%0b", r, cfg_err, m_cfg_err); end
      commit_valid = 1'b1; step(); commit_valid = 1'b0;
      wait_end(20, lat, d, t, hb, ee);
      if (d) for (int i = 0; i < N; i++) m_active[i] = m_shadow[i];
      total++; if (!d || lat != 4 || hb != 0 || ee != 0) begin bad++; $display("FAIL rnd_commit r=%0d lat=%0d done=%0b hold=%0d early=%0d want lat=4", r, lat, d, hb, ee); end
      total++; if (ep_ctrl !== exp_ep()) begin bad++; $display("FAIL rnd_ep r=%0d got=%0h want=%0h", r, ep_ctrl, exp_ep()); end
      step();
    end
    for (int c = 0; c < 160; c++) begin
      req_issue = (c < 80) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      req_done  = (c < 80) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      err_clr   = ($urandom_range(0, 15) == 0);
      step();
      if (c % 8 == 7) begin
        total++; if (dut.u_inflight.count !== 4'(m_cnt) || cnt_err !== m_cnt_err) begin bad++; $display("FAIL rnd_cnt c=%0d got=%0d/%0b want=%0d/%0b", c, dut.u_inflight.count, cnt_err, m_cnt, m_cnt_err); end
      end
    end
    req_issue = 1'b0; req_done = 1'b0; err_clr = 1'b0;
  endtask

  task automatic test_timeout();
    int lat, hb;
    logic [EW*N-1:0] t_ep0;
    while (m_cnt > 0) begin req_done = 1'b1; step(); end
    req_done = 1'b0;
    req_issue = 1'b1; step(); req_issue = 1'b0;
    total++; if (t_commit_ready !== 1'b1 || t_cfg_ready !== 1'b1) begin bad++; $display("FAIL tmo_ready got=%0b%0b want=11", t_commit_ready, t_cfg_ready); end
    t_ep0 = t_ep_ctrl;
    commit_valid = 1'b1; step(); commit_valid = 1'b0;
    lat = 1; hb = 0;
    while (lat <= 40) begin
      if (t_commit_timeout === 1'b1) break;
      if (t_gate_hold !== 1'b1) hb++;
      step();
      lat++;
    end
    total++; if (lat != 1 + TMO || hb != 0) begin bad++; $display("FAIL tmo_latency got=%0d hold_drop=%0d want=%0d", lat, hb, 1 + TMO); end
    step();
    total++; if (t_gate_hold !== 1'b0 || t_busy !== 1'b0 || t_commit_timeout !== 1'b0 || t_commit_done !== 1'b0) begin bad++; $display("FAIL tmo_after got=%0b%0b%0b%0b want=0000", t_gate_hold, t_busy, t_commit_timeout, t_commit_done); end
    total++; if (t_ep_ctrl !== t_ep0) begin bad++; $display("FAIL tmo_ep got=%0h want=%0h", t_ep_ctrl, t_ep0); end
    total++; if (t_cnt_err !== m_cnt_err || t_cfg_err !== m_cfg_err) begin bad++; $display("FAIL tmo_flags got=%0b%0b want=%0b%0b", t_cnt_err, t_cfg_err, m_cnt_err, m_cfg_err); end
    total++; if (gate_hold !== 1'b1) begin bad++; $display("FAIL main_still_hold got=%0b want=1", gate_hold); end
    req_done = 1'b1; step(); req_done = 1'b0;
    lat = 0;
    while (commit_done !== 1'b1 && lat < 10) begin step(); lat++; end
    if (commit_done === 1'b1) for (int i = 0; i < N; i++) m_active[i] = m_shadow[i];
    total++; if (commit_done !== 1'b1 || ep_ctrl !== exp_ep()) begin bad++; $display("FAIL main_finish got=%0b ep=%0h want=1 ep=%0h", commit_done, ep_ctrl, exp_ep()); end
    step();
  endtask

  task automatic test_reset_mid();
    req_issue = 1'b1; step(); req_issue = 1'b0;
    commit_valid = 1'b1; step(); commit_valid = 1'b0;
    repeat (3) step();
    total++; if (gate_hold !== 1'b1 || ep_ctrl !== exp_ep()) begin bad++; $display("FAIL pre_rst got=%0b ep=%0h want=1 ep=%0h", gate_hold, ep_ctrl, exp_ep()); end
    #1 areset = 1'b1;
    #1;
    model_reset();
    total++; if (ep_ctrl !== '0) begin bad++; $display("FAIL mid_rst_ep got=%0h want=0", ep_ctrl); end
    total++; if (gate_hold !== 1'b0 || busy !== 1'b0 || t_gate_hold !== 1'b0) begin bad++; $display("FAIL mid_rst_ctrl got=%0b%0b%0b want=000", gate_hold, busy, t_gate_hold); end
    @(posedge aclk);
    #1 areset = 1'b0;
    step();
    total++; if (cfg_ready !== 1'b1 || dut.u_inflight.count !== 4'd0) begin bad++; $display("FAIL post_rst got=%0b/%0d want=1/0", cfg_ready, dut.u_inflight.count); end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_commit();
    test_back_to_back();
    test_cfg_err();
    test_counter();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
